// File: rtl/ram_top.sv
// ram_top: 64x8 load-then-read buffer with a circular read pointer.
// Latency: a write lands on the edge it is requested; Dout updates on the edge that enters or slides READ.
// Backpressure: none; loads beyond 64 entries are dropped and Full stays asserted.
//
// Ports:
//   Clk      - sole clock, rising edge
//   Rst      - synchronous active-high reset (memory contents survive)
//   Ld       - load enable, writes Data_in at the fill position
//   Start    - read-mode request (wins over Ld)
//   Sliding  - advance the read pointer while in read mode
//   Data_in  - 8-bit write data
//   Cursor   - fill count outside READ, read pointer in READ
//   Empty    - fill count is zero
//   Full     - fill count is 64
//   using    - high while in READ
//   Dout     - registered read data
module ram_top (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Ld,
  input  logic       Start,
  input  logic       Sliding,
  input  logic [7:0] Data_in,
  output logic [6:0] Cursor,
  output logic       Empty,
  output logic       Full,
  output logic       using,
  output logic [7:0] Dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] mem [64];
  logic [6:0] cnt;
  logic [5:0] rp;

  logic       start_ok;
  logic       wr_en;
  logic       enter_read;
  logic       slide;
  logic       at_last;
  logic [5:0] rp_nxt;

  // Start only takes effect once something has been loaded.
  assign start_ok   = Start && (cnt != 7'd0);
  assign wr_en      = (state != READ) && Ld && !Start && (cnt != 7'd64);
  assign enter_read = (state != READ) && start_ok;
  assign slide      = (state == READ) && Sliding;
  // The pointer wraps at the fill count, not at the physical depth.
  assign at_last    = ({1'b0, rp} == (cnt - 7'd1));
  assign rp_nxt     = at_last ? 6'd0 : (rp + 6'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok)
          state_nxt = READ;
        else if (Ld && !Start)
          state_nxt = LOAD;
      end
      LOAD: begin
        if (start_ok)
          state_nxt = READ;
        else if (!Ld)
          state_nxt = IDLE;
      end
      READ: begin
        if (!Start)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= 7'd0;
      rp    <= 6'd0;
      Dout  <= 8'd0;
    end else begin
      state <= state_nxt;
      if (wr_en)
        cnt <= cnt + 7'd1;
      if (enter_read) begin
        rp   <= 6'd0;
        Dout <= mem[0];
      end else if (slide) begin
        rp   <= rp_nxt;
        Dout <= mem[rp_nxt];
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive Rst.
  always_ff @(posedge Clk) begin
    if (!Rst && wr_en)
      mem[cnt[5:0]] <= Data_in;
  end

  assign using  = (state == READ);
  assign Empty  = (cnt == 7'd0);
  assign Full   = (cnt == 7'd64);
  assign Cursor = (state == READ) ? {1'b0, rp} : cnt;

endmodule

// File: tb/tb_ram_top.sv
module tb_ram_top;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Ld = 1'b0;
  logic       Start = 1'b0;
  logic       Sliding = 1'b0;
  logic [7:0] Data_in = 8'd0;
  logic [6:0] Cursor;
  logic       Empty;
  logic       Full;
  logic       using;
  logic [7:0] Dout;

  ram_top dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Ld      (Ld),
    .Start   (Start),
    .Sliding (Sliding),
    .Data_in (Data_in),
    .Cursor  (Cursor),
    .Empty   (Empty),
    .Full    (Full),
    .using   (using),
    .Dout    (Dout)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  // Reference model: a buffer with a fill count, a read flag and a pointer.
  int m_mem [64];
  int m_cnt  = 0;
  int m_rp   = 0;
  int m_dout = 0;
  bit m_rd   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit l, input bit s, input bit sl,
                            input int d);
    if (r) begin
      m_rd = 0; m_cnt = 0; m_rp = 0; m_dout = 0;
    end else if (m_rd) begin
      if (sl) begin
        m_rp   = (m_rp + 1 == m_cnt) ? 0 : m_rp + 1;
        m_dout = m_mem[m_rp];
      end
      if (!s) m_rd = 0;
    end else if (s) begin
      if (m_cnt > 0) begin
        m_rd = 1; m_rp = 0; m_dout = m_mem[0];
      end
    end else if (l && m_cnt < 64) begin
      m_mem[m_cnt] = d;
      m_cnt++;
    end
  endtask

  // Apply one cycle of inputs; returns at the following falling edge.
  task automatic cyc(input bit r, input bit l, input bit s, input bit sl,
                     input int d);
    Rst = r; Ld = l; Start = s; Sliding = sl; Data_in = d[7:0];
    @(posedge Clk);
    model_step(r, l, s, sl, d);
    @(negedge Clk);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge Clk) begin
    if (armed) begin
      chk("cursor", int'(Cursor), m_rd ? m_rp : m_cnt);
      chk("empty",  int'(Empty),  int'(m_cnt == 0));
      chk("full",   int'(Full),   int'(m_cnt == 64));
      chk("using",  int'(using),  int'(m_rd));
      chk("dout",   int'(Dout),   m_dout);
    end
  end

  initial begin
    // Reset for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0);
      armed = 1'b1;
    end
    cyc(0, 0, 0, 0, 0);
    chk("rst_cursor", int'(Cursor), 0);
    chk("rst_empty",  int'(Empty), 1);
    chk("rst_full",   int'(Full), 0);
    chk("rst_using",  int'(using), 0);
    chk("rst_dout",   int'(Dout), 0);

    // 70 loads with Data_in = write index; the last 6 are dropped.
    for (int i = 0; i < 70; i++) begin
      cyc(0, 1, 0, 0, i);
      if (i == 0) chk("load_first_empty", int'(Empty), 0);
      if (i == 62) chk("load63_full", int'(Full), 0);
    end
    chk("load_cursor64", int'(Cursor), 64);
    chk("load_full", int'(Full), 1);

    // Enter READ and hold for 90 cycles.
    for (int i = 0; i < 90; i++) cyc(0, 0, 1, 0, 0);
    chk("hold_using",  int'(using), 1);
    chk("hold_cursor", int'(Cursor), 0);
    chk("hold_dout",   int'(Dout), 0);

    // Slide 70 times: Dout follows the pointer and wraps 63 -> 0.
    for (int i = 1; i <= 70; i++) begin
      cyc(0, 0, 1, 1, 0);
      if (i == 1)  chk("slide1_dout", int'(Dout), 1);
      if (i == 63) chk("slide63_cursor", int'(Cursor), 63);
      if (i == 63) chk("slide63_dout", int'(Dout), 63);
      if (i == 64) chk("wrap_cursor", int'(Cursor), 0);
      if (i == 64) chk("wrap_dout", int'(Dout), 0);
    end

    // Leave READ: fill count shows again and Dout is retained.
    cyc(0, 0, 0, 0, 0);
    chk("exit_using",  int'(using), 0);
    chk("exit_cursor", int'(Cursor), 64);
    chk("exit_dout",   int'(Dout), 6);

    // Three-byte buffer, sliding from entry.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 8'hA1);
    cyc(0, 1, 0, 0, 8'hB2);
    cyc(0, 1, 0, 0, 8'hC3);
    cyc(0, 0, 1, 1, 0);
    chk("small_d0", int'(Dout), 8'hA1);
    cyc(0, 0, 1, 1, 0);
    chk("small_d1", int'(Dout), 8'hB2);
    cyc(0, 0, 1, 1, 0);
    chk("small_d2", int'(Dout), 8'hC3);
    cyc(0, 0, 1, 1, 0);
    chk("small_d3", int'(Dout), 8'hA1);
    chk("small_full", int'(Full), 0);

    // Reset mid-read, then Start alone must be ignored.
    cyc(1, 0, 1, 1, 0);
    chk("midrst_using",  int'(using), 0);
    chk("midrst_cursor", int'(Cursor), 0);
    chk("midrst_empty",  int'(Empty), 1);
    chk("midrst_dout",   int'(Dout), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    chk("empty_start_using", int'(using), 0);

    // Start wins over Ld: no write on the entering edge.
    cyc(0, 1, 0, 0, 8'h55);
    cyc(0, 1, 1, 0, 8'h77);
    chk("prio_using", int'(using), 1);
    chk("prio_dout",  int'(Dout), 8'h55);
    cyc(0, 1, 0, 0, 8'h66);
    chk("prio_cursor", int'(Cursor), 1);
    cyc(0, 1, 0, 0, 8'h66);
    chk("after_cursor", int'(Cursor), 2);

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_top.md
RAM_TOP -- requirements
Module: ram_top

Interface
REQ-001 The block SHALL have these ports: Clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-002 Rst, input, 1 bit, SHALL be a synchronous active-high reset.
REQ-003 Ld, input, 1 bit, SHALL be the load enable: write Data_in into the buffer.
REQ-004 Start, input, 1 bit, SHALL be the read-mode request.
REQ-005 Sliding, input, 1 bit, SHALL advance the read pointer while in read mode.
REQ-006 Data_in, input, 8 bits, SHALL be the write data.
REQ-007 Cursor, output, 7 bits, SHALL show the fill count (LOAD/IDLE) or the read pointer (READ).
REQ-008 Empty, Full, using, outputs, 1 bit each, SHALL flag count==0, count==64 and read mode respectively.
REQ-009 Dout, output, 8 bits, SHALL be registered read data.

Function
REQ-010 Storage SHALL be 64 entries x 8 bits, with a 7-bit fill count cnt (0..64) and a 6-bit read pointer rp.
REQ-011 FSM states SHALL be IDLE, LOAD and READ; reset state IDLE.
REQ-012 IDLE -> LOAD SHALL occur when Ld=1 and Start=0; IDLE or LOAD -> READ SHALL occur when Start=1 and cnt>0.
REQ-013 Start=1 with cnt==0 SHALL leave the state unchanged.
REQ-014 In IDLE or LOAD, each edge with Ld=1, Start=0 and cnt<64 SHALL write mem[cnt]<=Data_in and increment cnt by one, with zero extra latency.
REQ-015 Ld=1 with cnt==64 SHALL be ignored: no write, cnt held at 64.
REQ-016 LOAD -> IDLE SHALL occur when Ld=0.
REQ-017 Start SHALL have priority over Ld; no write SHALL occur on the edge that enters READ or in any READ cycle.
REQ-018 On entry to READ, rp SHALL be 0 and Dout SHALL become mem[0] on that same edge.
REQ-019 In READ with Sliding=1, each edge SHALL set rp to rp+1 and Dout to mem[rp+1].
REQ-020 In READ, when rp==cnt-1 and Sliding=1, the next edge SHALL wrap rp to 0 and set Dout to mem[0].
REQ-021 In READ with Sliding=0, rp and Dout SHALL hold.
REQ-022 READ -> IDLE SHALL occur when Start=0; cnt, memory contents and Dout SHALL be retained.
REQ-023 Outputs SHALL be: using=1 only in READ; Empty=(cnt==0); Full=(cnt==64); Cursor=cnt outside READ and Cursor={1'b0,rp} in READ.
REQ-024 Empty, Full, using and Cursor SHALL be registered or decoded from registered state, with no combinational path from inputs.

Reset
REQ-025 On Rst=1 at a Clk edge: state=IDLE, cnt=0, rp=0, Dout=0, using=0, Empty=1, Full=0, Cursor=0.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 Rst SHALL override all other inputs, including in mid-load and mid-read.

Verification
REQ-028 Scenario: Rst=1 for 5 cycles, then release -> Cursor=0, Empty=1, Full=0, using=0, Dout=0.
REQ-029 Scenario: Ld=1 for 70 cycles with Data_in=i on write i -> Cursor counts 1..64, Empty falls after the first write, Full=1 after the 64th, writes 65-70 ignored.
REQ-030 Scenario: after a full load, Start=1, Sliding=0 -> using=1, Cursor=0, Dout=0x00, held for 90 cycles.
REQ-031 Scenario: then Sliding=1 for 70 cycles -> Dout=1,2,...,63,0,1..., Cursor wraps 63->0.
REQ-032 Scenario: load 3 bytes (0xA1, 0xB2, 0xC3), Start=1, Sliding=1 -> Dout cycles A1,B2,C3,A1; Full=0.
REQ-033 Scenario: Rst=1 mid-read -> the next edge gives using=0, Cursor=0, Empty=1, Dout=0; Start=1 afterwards is ignored until a new load.
